// File: rtl/rrf_freelist_pkg.sv
// Shared constants for the RRF free-list: entry count and tag width.
// Every rrf_freelist file takes its sizes from here.
package rrf_freelist_pkg;

   localparam int C_RRF_NUM = 64;
   localparam int C_RRF_SEL = 6;

   typedef enum logic [1:0] {
      CNT_NONE = 2'd0,
      CNT_ONE  = 2'd1,
      CNT_TWO  = 2'd2
   } slot_cnt_e;

endpackage

// File: rtl/rrf_freelist_if.sv
// Rename/commit interface of the RRF free-list.
// flush_i is present only when RRF_FLUSH_EN is defined.
interface rrf_freelist_if #(
   parameter int RRF_SEL = rrf_freelist_pkg::C_RRF_SEL
);
   logic [1:0]         req_num_i;
   logic               stall_i;
   logic [1:0]         com_num_i;
`ifdef RRF_FLUSH_EN
   logic               flush_i;
`endif
   logic               allocatable_o;
   logic               alloc_en1_o;
   logic               alloc_en2_o;
   logic [RRF_SEL-1:0] alloc_tag1_o;
   logic [RRF_SEL-1:0] alloc_tag2_o;
   logic [RRF_SEL-1:0] com_tag1_o;
   logic [RRF_SEL-1:0] com_tag2_o;
   logic [RRF_SEL-1:0] rrfptr_o;
   logic [RRF_SEL-1:0] comptr_o;
   logic [RRF_SEL:0]   freenum_o;
   logic               nextrrfcyc_o;

   modport slave (
      input  req_num_i, stall_i, com_num_i,
`ifdef RRF_FLUSH_EN
      input  flush_i,
`endif
      output allocatable_o, alloc_en1_o, alloc_en2_o, alloc_tag1_o, alloc_tag2_o,
             com_tag1_o, com_tag2_o, rrfptr_o, comptr_o, freenum_o, nextrrfcyc_o
   );

   modport master (
      output req_num_i, stall_i, com_num_i,
`ifdef RRF_FLUSH_EN
      output flush_i,
`endif
      input  allocatable_o, alloc_en1_o, alloc_en2_o, alloc_tag1_o, alloc_tag2_o,
             com_tag1_o, com_tag2_o, rrfptr_o, comptr_o, freenum_o, nextrrfcyc_o
   );
endinterface

// File: rtl/rrf_freelist_ptr_adv.sv
// Circular pointer advance by 0/1/2 with a flag for crossing the top entry.
module rrf_ptr_adv #(
   parameter int SEL = rrf_freelist_pkg::C_RRF_SEL
) (
   input  logic [SEL-1:0] ptr_i,
   input  logic [1:0]     inc_i,
   output logic [SEL-1:0] next_o,
   output logic           wrap_o
);
   logic [SEL:0] sum;

   assign sum    = {1'b0, ptr_i} + {{(SEL-1){1'b0}}, inc_i};
   assign next_o = sum[SEL-1:0];
   assign wrap_o = sum[SEL];
endmodule

// File: rtl/rrf_freelist.sv
// RRF tag allocator and in-order retirement tracker.
// Define RRF_FLUSH_EN to add flush_i misprediction recovery.
module rrf_freelist
   import rrf_freelist_pkg::*;
#(
   parameter int RRF_NUM = C_RRF_NUM,
   parameter int RRF_SEL = C_RRF_SEL
) (
   input logic           clk,
   input logic           reset,
   rrf_freelist_if.slave fl
);
   logic [RRF_SEL-1:0] rrfptr_q, rrfptr_d;
   logic [RRF_SEL-1:0] comptr_q, comptr_d;
   logic [RRF_SEL:0]   freenum_q, freenum_d;
   logic               nextrrfcyc_q, nextrrfcyc_d;

   logic               allocatable;
   logic               fire;
   logic [1:0]         alloc_num;
   logic [RRF_SEL-1:0] rrf_next, com_next;
   logic               rrf_wrap, com_wrap;

   rrf_ptr_adv #(.SEL(RRF_SEL)) u_rrf_adv (
      .ptr_i  (rrfptr_q),
      .inc_i  (alloc_num),
      .next_o (rrf_next),
      .wrap_o (rrf_wrap)
   );

   rrf_ptr_adv #(.SEL(RRF_SEL)) u_com_adv (
      .ptr_i  (comptr_q),
      .inc_i  (fl.com_num_i),
      .next_o (com_next),
      .wrap_o (com_wrap)
   );

   // Allocation sees only the registered count, so same-cycle frees wait a cycle.
   always_comb begin
      allocatable = (freenum_q >= {{(RRF_SEL-1){1'b0}}, fl.req_num_i});
      fire        = allocatable & ~fl.stall_i & (fl.req_num_i != CNT_NONE);
`ifdef RRF_FLUSH_EN
      fire        = fire & ~fl.flush_i;
`endif
      alloc_num   = fire ? fl.req_num_i : CNT_NONE;
   end

`ifdef RRF_FLUSH_EN
   logic comcyc_q, comcyc_d;

   // comcyc tracks the wrap parity of comptr so a flush can restore nextrrfcyc.
   always_comb begin
      comcyc_d     = comcyc_q ^ com_wrap;
      rrfptr_d     = rrf_next;
      comptr_d     = com_next;
      freenum_d    = freenum_q - {{(RRF_SEL-1){1'b0}}, alloc_num}
                               + {{(RRF_SEL-1){1'b0}}, fl.com_num_i};
      nextrrfcyc_d = nextrrfcyc_q ^ rrf_wrap;
      if (fl.flush_i) begin
         rrfptr_d     = com_next;
         freenum_d    = (RRF_SEL+1)'(RRF_NUM);
         nextrrfcyc_d = comcyc_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) comcyc_q <= 1'b0;
      else       comcyc_q <= comcyc_d;
   end
`else
   logic com_wrap_unused;

   assign com_wrap_unused = com_wrap;

   always_comb begin
      rrfptr_d     = rrf_next;
      comptr_d     = com_next;
      freenum_d    = freenum_q - {{(RRF_SEL-1){1'b0}}, alloc_num}
                               + {{(RRF_SEL-1){1'b0}}, fl.com_num_i};
      nextrrfcyc_d = nextrrfcyc_q ^ rrf_wrap;
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rrfptr_q     <= '0;
         comptr_q     <= '0;
         freenum_q    <= (RRF_SEL+1)'(RRF_NUM);
         nextrrfcyc_q <= 1'b0;
      end else begin
         rrfptr_q     <= rrfptr_d;
         comptr_q     <= comptr_d;
         freenum_q    <= freenum_d;
         nextrrfcyc_q <= nextrrfcyc_d;
      end
   end

   assign fl.allocatable_o = allocatable;
   assign fl.alloc_en1_o   = fire;
   assign fl.alloc_en2_o   = fire & (fl.req_num_i == CNT_TWO);
   assign fl.alloc_tag1_o  = rrfptr_q;
   assign fl.alloc_tag2_o  = rrfptr_q + RRF_SEL'(1);
   assign fl.com_tag1_o    = comptr_q;
   assign fl.com_tag2_o    = comptr_q + RRF_SEL'(1);
   assign fl.rrfptr_o      = rrfptr_q;
   assign fl.comptr_o      = comptr_q;
   assign fl.freenum_o     = freenum_q;
   assign fl.nextrrfcyc_o  = nextrrfcyc_q;
endmodule

// File: tb/tb_rrf_freelist.sv
// Directed bench for rrf_freelist: fill, full, commit, stall, wrap and async reset.
// The flush scenario is compiled in only with RRF_FLUSH_EN.
module tb_rrf_freelist;
   import rrf_freelist_pkg::*;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;

   rrf_freelist_if fl_if ();

   rrf_freelist dut (
      .clk   (clk),
      .reset (reset),
      .fl    (fl_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Retiring more entries than are in flight is illegal stimulus.
   always @(posedge clk) begin
      if (!reset && (int'(fl_if.com_num_i) > C_RRF_NUM - int'(fl_if.freenum_o)))
         $display("[TB] error: com_num_i %0d exceeds occupied entries", fl_if.com_num_i);
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] req, input logic stall, input logic [1:0] com);
      @(negedge clk);
      fl_if.req_num_i = req;
      fl_if.stall_i   = stall;
      fl_if.com_num_i = com;
      #1;
   endtask

   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset = 1'b1;
      fl_if.req_num_i = 2'd0;
      fl_if.stall_i   = 1'b0;
      fl_if.com_num_i = 2'd0;
`ifdef RRF_FLUSH_EN
      fl_if.flush_i   = 1'b0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      applyStimulus(2'd0, 1'b0, 2'd0);
      checkOutput("rst_rrfptr",      int'(fl_if.rrfptr_o),      0);
      checkOutput("rst_comptr",      int'(fl_if.comptr_o),      0);
      checkOutput("rst_freenum",     int'(fl_if.freenum_o),     64);
      checkOutput("rst_nextrrfcyc",  int'(fl_if.nextrrfcyc_o),  0);
      checkOutput("rst_alloc_tag1",  int'(fl_if.alloc_tag1_o),  0);
      checkOutput("rst_alloc_tag2",  int'(fl_if.alloc_tag2_o),  1);
      checkOutput("rst_com_tag1",    int'(fl_if.com_tag1_o),    0);
      checkOutput("rst_com_tag2",    int'(fl_if.com_tag2_o),    1);
      checkOutput("rst_allocatable", int'(fl_if.allocatable_o), 1);

      for (int i = 0; i < 32; i++) begin
         applyStimulus(2'd2, 1'b0, 2'd0);
         checkOutput("fill_en1",  int'(fl_if.alloc_en1_o),  1);
         checkOutput("fill_en2",  int'(fl_if.alloc_en2_o),  1);
         checkOutput("fill_tag1", int'(fl_if.alloc_tag1_o), 2 * i);
         checkOutput("fill_tag2", int'(fl_if.alloc_tag2_o), 2 * i + 1);
         stepClock();
         checkOutput("fill_freenum", int'(fl_if.freenum_o), 62 - 2 * i);
      end
      checkOutput("full_rrfptr",     int'(fl_if.rrfptr_o),     0);
      checkOutput("full_nextrrfcyc", int'(fl_if.nextrrfcyc_o), 1);

      applyStimulus(2'd1, 1'b0, 2'd0);
      checkOutput("full_allocatable_req1", int'(fl_if.allocatable_o), 0);
      checkOutput("full_en1_req1",         int'(fl_if.alloc_en1_o),   0);
      applyStimulus(2'd0, 1'b0, 2'd0);
      checkOutput("full_allocatable_req0", int'(fl_if.allocatable_o), 1);

      applyStimulus(2'd1, 1'b0, 2'd2);
      checkOutput("fullcom_allocatable", int'(fl_if.allocatable_o), 0);
      checkOutput("fullcom_en1",         int'(fl_if.alloc_en1_o),   0);
      checkOutput("fullcom_com_tag1",    int'(fl_if.com_tag1_o),    0);
      checkOutput("fullcom_com_tag2",    int'(fl_if.com_tag2_o),    1);
      stepClock();
      checkOutput("fullcom_freenum", int'(fl_if.freenum_o), 2);
      checkOutput("fullcom_comptr",  int'(fl_if.comptr_o),  2);
      checkOutput("fullcom_rrfptr",  int'(fl_if.rrfptr_o),  0);

      applyStimulus(2'd1, 1'b0, 2'd0);
      checkOutput("freed_allocatable", int'(fl_if.allocatable_o), 1);
      checkOutput("freed_tag1",        int'(fl_if.alloc_tag1_o),  0);
      stepClock();
      checkOutput("freed_freenum", int'(fl_if.freenum_o), 1);

      applyStimulus(2'd2, 1'b0, 2'd0);
      checkOutput("one_req2_allocatable", int'(fl_if.allocatable_o), 0);
      checkOutput("one_req2_en1",         int'(fl_if.alloc_en1_o),   0);
      applyStimulus(2'd1, 1'b0, 2'd0);
      checkOutput("one_req1_allocatable", int'(fl_if.allocatable_o), 1);
      checkOutput("one_req1_en1",         int'(fl_if.alloc_en1_o),   1);
      checkOutput("one_req1_en2",         int'(fl_if.alloc_en2_o),   0);
      checkOutput("one_req1_tag1",        int'(fl_if.alloc_tag1_o),  1);
      stepClock();
      checkOutput("one_req1_freenum", int'(fl_if.freenum_o), 0);
      checkOutput("one_req1_rrfptr",  int'(fl_if.rrfptr_o),  2);

      for (int i = 0; i < 10; i++) begin
         applyStimulus(2'd0, 1'b0, 2'd2);
         stepClock();
      end
      checkOutput("retire_comptr",  int'(fl_if.comptr_o),  22);
      checkOutput("retire_freenum", int'(fl_if.freenum_o), 20);

      applyStimulus(2'd2, 1'b1, 2'd0);
      checkOutput("stall_en1", int'(fl_if.alloc_en1_o), 0);
      checkOutput("stall_en2", int'(fl_if.alloc_en2_o), 0);
      stepClock();
      checkOutput("stall_rrfptr",  int'(fl_if.rrfptr_o),  2);
      checkOutput("stall_freenum", int'(fl_if.freenum_o), 20);

      applyStimulus(2'd2, 1'b0, 2'd1);
      checkOutput("both_tag1", int'(fl_if.alloc_tag1_o), 2);
      checkOutput("both_tag2", int'(fl_if.alloc_tag2_o), 3);
      stepClock();
      checkOutput("both_rrfptr",  int'(fl_if.rrfptr_o),  4);
      checkOutput("both_comptr",  int'(fl_if.comptr_o),  23);
      checkOutput("both_freenum", int'(fl_if.freenum_o), 19);

      for (int i = 0; i < 29; i++) begin
         applyStimulus(2'd2, 1'b0, 2'd2);
         stepClock();
      end
      checkOutput("steady_rrfptr",  int'(fl_if.rrfptr_o),  62);
      checkOutput("steady_comptr",  int'(fl_if.comptr_o),  17);
      checkOutput("steady_freenum", int'(fl_if.freenum_o), 19);
      checkOutput("steady_com_tag2", int'(fl_if.com_tag2_o), 18);

      applyStimulus(2'd1, 1'b0, 2'd0);
      stepClock();
      checkOutput("pre_wrap_rrfptr", int'(fl_if.rrfptr_o), 63);
      applyStimulus(2'd2, 1'b0, 2'd0);
      checkOutput("wrap_tag1", int'(fl_if.alloc_tag1_o), 63);
      checkOutput("wrap_tag2", int'(fl_if.alloc_tag2_o), 0);
      stepClock();
      checkOutput("wrap_rrfptr",     int'(fl_if.rrfptr_o),     1);
      checkOutput("wrap_nextrrfcyc", int'(fl_if.nextrrfcyc_o), 0);
      checkOutput("wrap_freenum",    int'(fl_if.freenum_o),    16);

      applyStimulus(2'd0, 1'b0, 2'd0);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_rst_rrfptr",     int'(fl_if.rrfptr_o),     0);
      checkOutput("async_rst_comptr",     int'(fl_if.comptr_o),     0);
      checkOutput("async_rst_freenum",    int'(fl_if.freenum_o),    64);
      checkOutput("async_rst_nextrrfcyc", int'(fl_if.nextrrfcyc_o), 0);
      @(negedge clk);
      reset = 1'b0;

`ifdef RRF_FLUSH_EN
      for (int i = 0; i < 10; i++) begin
         applyStimulus(2'd2, 1'b0, 2'd0);
         stepClock();
      end
      for (int i = 0; i < 5; i++) begin
         applyStimulus(2'd0, 1'b0, 2'd2);
         stepClock();
      end
      checkOutput("preflush_rrfptr", int'(fl_if.rrfptr_o), 20);
      checkOutput("preflush_comptr", int'(fl_if.comptr_o), 10);
      applyStimulus(2'd2, 1'b0, 2'd1);
      fl_if.flush_i = 1'b1;
      #1;
      checkOutput("flush_en1", int'(fl_if.alloc_en1_o), 0);
      stepClock();
      fl_if.flush_i = 1'b0;
      checkOutput("flush_rrfptr",     int'(fl_if.rrfptr_o),     11);
      checkOutput("flush_comptr",     int'(fl_if.comptr_o),     11);
      checkOutput("flush_freenum",    int'(fl_if.freenum_o),    64);
      checkOutput("flush_nextrrfcyc", int'(fl_if.nextrrfcyc_o), 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
